// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard-unit controls, ID-stage redirects, instruction-memory
// port and the IF/ID register outputs.
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    logic             PCWrite;
    logic             IF_ID_Write;
    logic             branch_taken;
    logic [31:0]      branch_target;
    logic             jump;
    logic [31:0]      jump_target;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      pc;
    logic [31:0]      IF_ID_instr;
    logic [31:0]      IF_ID_pc4;
    logic             IF_ID_valid;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    // Surrounding pipeline / memory side.
    modport master (
        output PCWrite, IF_ID_Write, branch_taken, branch_target,
               jump, jump_target, imem_rdata,
        input  imem_addr, pc, IF_ID_instr, IF_ID_pc4, IF_ID_valid,
               stall_count, flush_count
    );

    // Fetch stage side.
    modport slave (
        input  PCWrite, IF_ID_Write, branch_taken, branch_target,
               jump, jump_target, imem_rdata,
        output imem_addr, pc, IF_ID_instr, IF_ID_pc4, IF_ID_valid,
               stall_count, flush_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage with IF/ID pipeline register. Holds PC and IF/ID on stall,
// inserts one NOP bubble on a taken branch/jump, and keeps saturating
// stall/flush cycle counters for performance debug.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input logic         clk,
    input logic         reset_n,
    fetch_stage_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_reg;
    logic [31:0]      pc_next;
    logic [31:0]      pc_plus4;
    logic [31:0]      target;
    logic             redirect;
    logic [31:0]      instr_reg;
    logic [31:0]      pc4_reg;
    logic             valid_reg;
    logic [CNT_W-1:0] stall_reg;
    logic [CNT_W-1:0] flush_reg;

    // Next-PC selection; a redirect seen while stalled is dropped because the
    // stalled ID instruction will raise it again once the stall clears.
    always_comb begin
        pc_plus4 = pc_reg + 32'd4;
        redirect = (bus.branch_taken | bus.jump) & bus.PCWrite;
        target   = bus.branch_taken ? bus.branch_target : bus.jump_target;
        target   = {target[31:2], 2'b00};
        pc_next  = pc_reg;
        if (bus.PCWrite) begin
            pc_next = redirect ? target : pc_plus4;
        end
    end

    // PC, IF/ID register and performance counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_reg    <= RESET_PC;
            instr_reg <= NOP_INSTR;
            pc4_reg   <= 32'd0;
            valid_reg <= 1'b0;
            stall_reg <= '0;
            flush_reg <= '0;
        end else begin
            pc_reg <= pc_next;
            if (bus.IF_ID_Write) begin
                if (redirect) begin
                    instr_reg <= NOP_INSTR;
                    pc4_reg   <= 32'd0;
                    valid_reg <= 1'b0;
                end else begin
                    instr_reg <= bus.imem_rdata;
                    pc4_reg   <= pc_plus4;
                    valid_reg <= 1'b1;
                end
            end
            if (!bus.PCWrite && stall_reg != CNT_MAX) begin
                stall_reg <= stall_reg + 1'b1;
            end
            if (redirect && flush_reg != CNT_MAX) begin
                flush_reg <= flush_reg + 1'b1;
            end
        end
    end

    assign bus.imem_addr   = pc_reg;
    assign bus.pc          = pc_reg;
    assign bus.IF_ID_instr = instr_reg;
    assign bus.IF_ID_pc4   = pc4_reg;
    assign bus.IF_ID_valid = valid_reg;
    assign bus.stall_count = stall_reg;
    assign bus.flush_count = flush_reg;
endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table, randomized run against a
// behavioural model, and a second instance for counter saturation / PC wrap.
module tb_fetch_stage;
    logic clk = 1'b0;
    logic reset_n;
    logic reset_n2;
    logic beef;

    int checks = 0;
    int errors = 0;

    fetch_stage_if #(.CNT_W(16)) bus ();
    fetch_stage_if #(.CNT_W(2))  bus2 ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n2), .bus(bus2.slave)
    );

    always #5 clk = ~clk;

    // Instruction memory: word at address a holds a+1 (so imem[n]=n*4+1).
    always_comb begin
        bus.imem_rdata  = beef ? 32'hDEAD_BEEF : bus.imem_addr + 32'd1;
        bus2.imem_rdata = bus2.imem_addr + 32'd1;
    end

    typedef struct packed {
        logic        rst_n;
        logic        pcw;
        logic        ifw;
        logic        b;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        beef;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_stall;
        logic [15:0] e_flush;
    } vec_t;

    vec_t vecs [23];

    // Behavioural model state.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    int          m_stall, m_flush;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic pcw, input logic ifw,
                         input logic b, input logic [31:0] bt,
                         input logic j, input logic [31:0] jt);
        reset_n           = rst_n;
        bus.PCWrite       = pcw;
        bus.IF_ID_Write   = ifw;
        bus.branch_taken  = b;
        bus.branch_target = bt;
        bus.jump          = j;
        bus.jump_target   = jt;
    endtask

    // Next-state of the model from the rules; rdata is what memory returns at m_pc.
    task automatic model_step(input logic rst_n, input logic pcw, input logic ifw,
                              input logic b, input logic [31:0] bt,
                              input logic j, input logic [31:0] jt,
                              input logic [31:0] rdata, input int cmax);
        logic        redir;
        logic [31:0] tgt;
        logic [31:0] old_pc;
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            m_stall = 0; m_flush = 0;
            return;
        end
        old_pc = m_pc;
        redir  = (b || j) && pcw;
        tgt    = b ? bt : jt;
        tgt    = tgt & 32'hFFFF_FFFC;
        if (pcw) m_pc = redir ? tgt : old_pc + 32'd4;
        if (ifw) begin
            if (redir) begin
                m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            end else begin
                m_instr = rdata; m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
            end
        end
        if (!pcw && m_stall < cmax) m_stall++;
        if (redir && m_flush < cmax) m_flush++;
    endtask

    task automatic step2(input logic rst_n, input logic pcw, input logic b, input logic [31:0] bt);
        reset_n2           = rst_n;
        bus2.PCWrite       = pcw;
        bus2.IF_ID_Write   = pcw;
        bus2.branch_taken  = b;
        bus2.branch_target = bt;
        bus2.jump          = 1'b0;
        bus2.jump_target   = 32'h0;
        @(posedge clk); #1;
        $display("dut2 rst_n=%b pcw=%b b=%b -> pc=%h stall=%0d flush=%0d",
                 rst_n, pcw, b, bus2.pc, bus2.stall_count, bus2.flush_count);
    endtask

    initial begin
        // rst pcw ifw b bt j jt beef | pc instr pc4 valid stall flush
        vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b1, 32'h0,  32'h0,  32'h0,  1'b0,16'd0,16'd0};
        vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b1, 32'h0,  32'h0,  32'h0,  1'b0,16'd0,16'd0};
        vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h4,  32'h1,  32'h4,  1'b1,16'd0,16'd0};
        vecs[3]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h8,  32'h5,  32'h8,  1'b1,16'd0,16'd0};
        vecs[4]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'hC,  32'h9,  32'hC,  1'b1,16'd0,16'd0};
        vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h10, 32'hD,  32'h10, 1'b1,16'd0,16'd0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h10, 32'hD,  32'h10, 1'b1,16'd1,16'd0};
        vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h10, 32'hD,  32'h10, 1'b1,16'd2,16'd0};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h14, 32'h11, 32'h14, 1'b1,16'd2,16'd0};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h18, 32'h15, 32'h18, 1'b1,16'd2,16'd0};
        vecs[10] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h1C, 32'h19, 32'h1C, 1'b1,16'd2,16'd0};
        vecs[11] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h20, 32'h1D, 32'h20, 1'b1,16'd2,16'd0};
        vecs[12] = '{1'b1,1'b1,1'b1,1'b1,32'h43, 1'b0,32'h0,  1'b0, 32'h40, 32'h0,  32'h0,  1'b0,16'd2,16'd1};
        vecs[13] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h44, 32'h41, 32'h44, 1'b1,16'd2,16'd1};
        vecs[14] = '{1'b1,1'b1,1'b1,1'b1,32'h100,1'b1,32'h200,1'b0, 32'h100,32'h0,  32'h0,  1'b0,16'd2,16'd2};
        vecs[15] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h104,32'h101,32'h104,1'b1,16'd2,16'd2};
        vecs[16] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b1,32'h202,1'b0, 32'h200,32'h0,  32'h0,  1'b0,16'd2,16'd3};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b1,32'h300,1'b0,32'h0,  1'b0, 32'h200,32'h0,  32'h0,  1'b0,16'd3,16'd3};
        vecs[18] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h204,32'h201,32'h204,1'b1,16'd3,16'd3};
        vecs[19] = '{1'b0,1'b0,1'b0,1'b1,32'h300,1'b0,32'h0,  1'b0, 32'h0,  32'h0,  32'h0,  1'b0,16'd0,16'd0};
        vecs[20] = '{1'b1,1'b1,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h4,  32'h1,  32'h4,  1'b1,16'd0,16'd0};
        vecs[21] = '{1'b1,1'b1,1'b0,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h8,  32'h1,  32'h4,  1'b1,16'd0,16'd0};
        vecs[22] = '{1'b1,1'b0,1'b1,1'b0,32'h0,  1'b0,32'h0,  1'b0, 32'h8,  32'h9,  32'hC,  1'b1,16'd1,16'd0};

        beef = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        step2_idle();
        @(posedge clk); #1;

        // Directed table.
        for (int i = 0; i < 23; i++) begin
            drive(vecs[i].rst_n, vecs[i].pcw, vecs[i].ifw, vecs[i].b, vecs[i].bt, vecs[i].j, vecs[i].jt);
            beef = vecs[i].beef;
            @(posedge clk); #1;
            $display("vec %0d: pc=%h instr=%h pc4=%h valid=%b stall=%0d flush=%0d",
                     i, bus.pc, bus.IF_ID_instr, bus.IF_ID_pc4, bus.IF_ID_valid,
                     bus.stall_count, bus.flush_count);
            check($sformatf("vec%0d pc", i),    bus.pc,          vecs[i].e_pc);
            check($sformatf("vec%0d imem_addr", i), bus.imem_addr, vecs[i].e_pc);
            check($sformatf("vec%0d instr", i), bus.IF_ID_instr, vecs[i].e_instr);
            check($sformatf("vec%0d pc4", i),   bus.IF_ID_pc4,   vecs[i].e_pc4);
            check($sformatf("vec%0d valid", i), {31'd0, bus.IF_ID_valid}, {31'd0, vecs[i].e_valid});
            check($sformatf("vec%0d stall", i), {16'd0, bus.stall_count}, {16'd0, vecs[i].e_stall});
            check($sformatf("vec%0d flush", i), {16'd0, bus.flush_count}, {16'd0, vecs[i].e_flush});
        end

        // Randomized run against the model, starting from a reset.
        beef = 1'b0;
        model_step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 65535);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            logic        r, pw, iw, b, j;
            logic [31:0] bt, jt;
            r  = ($urandom_range(0, 31) != 0);
            pw = ($urandom_range(0, 3) != 0);
            iw = ($urandom_range(0, 7) == 0) ? ~pw : pw;
            b  = ($urandom_range(0, 4) == 0);
            j  = ($urandom_range(0, 4) == 0);
            bt = $urandom;
            jt = $urandom;
            drive(r, pw, iw, b, bt, j, jt);
            model_step(r, pw, iw, b, bt, j, jt, m_pc + 32'd1, 65535);
            @(posedge clk); #1;
            $display("rnd %0d: rst_n=%b pcw=%b ifw=%b b=%b j=%b -> pc=%h instr=%h valid=%b",
                     n, r, pw, iw, b, j, bus.pc, bus.IF_ID_instr, bus.IF_ID_valid);
            check("rnd pc",    bus.pc,          m_pc);
            check("rnd instr", bus.IF_ID_instr, m_instr);
            check("rnd pc4",   bus.IF_ID_pc4,   m_pc4);
            check("rnd valid", {31'd0, bus.IF_ID_valid}, {31'd0, m_valid});
            check("rnd stall", {16'd0, bus.stall_count}, m_stall);
            check("rnd flush", {16'd0, bus.flush_count}, m_flush);
        end

        // Second instance: PC wrap from FFFF_FFFC and 2-bit counter saturation.
        step2(1'b0, 1'b1, 1'b0, 32'h0);
        check("wrap reset pc", bus2.pc, 32'hFFFF_FFFC);
        step2(1'b1, 1'b1, 1'b0, 32'h0);
        check("wrap pc",    bus2.pc,          32'h0);
        check("wrap instr", bus2.IF_ID_instr, 32'hFFFF_FFFD);
        check("wrap pc4",   bus2.IF_ID_pc4,   32'h0);
        for (int k = 1; k <= 5; k++) begin
            step2(1'b1, 1'b0, 1'b0, 32'h0);
            check($sformatf("sat stall %0d", k), {30'd0, bus2.stall_count}, (k > 3) ? 32'd3 : k);
            check($sformatf("sat stall pc %0d", k), bus2.pc, 32'h0);
        end
        for (int k = 1; k <= 4; k++) begin
            step2(1'b1, 1'b1, 1'b1, 32'h10);
            check($sformatf("sat flush %0d", k), {30'd0, bus2.flush_count}, (k > 3) ? 32'd3 : k);
            check($sformatf("sat flush pc %0d", k), bus2.pc, 32'h10);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic step2_idle();
        reset_n2           = 1'b0;
        bus2.PCWrite       = 1'b1;
        bus2.IF_ID_Write   = 1'b1;
        bus2.branch_taken  = 1'b0;
        bus2.branch_target = 32'h0;
        bus2.jump          = 1'b0;
        bus2.jump_target   = 32'h0;
    endtask
endmodule
